// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding and sizing helper for the sequential ALU.
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bits needed to hold values 0..n-1; call with WIDTH+1 to size the iteration counter.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/alu_seq_if.sv
// Operand-issue / result-writeback handshake bundle for alu_seq.
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] Input_1;
  logic [WIDTH-1:0] Input_2;
  logic [3:0]       Select_Input;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Output_Signal;
  logic [WIDTH-1:0] Output_High;
  logic             Carry_Output;
  logic             Zero_Flag;
  logic             Div_By_Zero;

  modport master (
    output In_Valid, Input_1, Input_2, Select_Input, Out_Ready,
    input  In_Ready, Out_Valid, Output_Signal, Output_High,
           Carry_Output, Zero_Flag, Div_By_Zero
  );
  modport slave (
    input  In_Valid, Input_1, Input_2, Select_Input, Out_Ready,
    output In_Ready, Out_Valid, Output_Signal, Output_High,
           Carry_Output, Zero_Flag, Div_By_Zero
  );
endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle.
// lo/hi are the next-step values; on the cycle done is high they are the final result.
module alu_iter_muldiv import alu_seq_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,   // 1 = divide
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             done
);
  localparam int CW = clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_b;
  logic             r_div;
  logic [WIDTH:0]   add_s, sh;
  logic [WIDTH-1:0] dif;

  // hi:lo is a shared accumulator: product halves for MUL, remainder:quotient for DIV
  always_comb begin
    add_s = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    sh    = {r_hi, r_lo[WIDTH-1]};
    dif   = sh[WIDTH-1:0] - r_b;
    if (r_div) begin
      if (sh >= {1'b0, r_b}) begin
        hi = dif;
        lo = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi = sh[WIDTH-1:0];
        lo = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi = add_s[WIDTH:1];
      lo = {add_s[0], r_lo[WIDTH-1:1]};
    end
  end

  assign done = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      r_hi  <= '0;
      r_lo  <= a;
      r_b   <= b;
      r_div <= mode;
      cnt   <= CW'(WIDTH);
    end else if (cnt != '0) begin
      r_hi <= hi;
      r_lo <= lo;
      cnt  <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: IDLE/BUSY/DONE handshake FSM, single-cycle ops and flags;
// MUL and non-zero DIV are handed to the iterative unit.
module alu_seq import alu_seq_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic      Clock,
  input  logic      Reset,
  alu_seq_if.slave  bus
);
  state_t           state;
  logic             op_div;
  logic             iter_op, start;
  logic [WIDTH-1:0] a, b, sc_lo, sc_hi, md_lo, md_hi;
  logic             sc_c, sc_dz, md_done;
  logic [WIDTH:0]   sum, dif;

  assign a       = bus.Input_1;
  assign b       = bus.Input_2;
  assign iter_op = (bus.Select_Input == OP_MUL) ||
                   (bus.Select_Input == OP_DIV && b != '0);
  assign start   = (state == S_IDLE) && bus.In_Valid && iter_op;

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (Clock),
    .rst   (Reset),
    .start (start),
    .mode  (bus.Select_Input == OP_DIV),
    .a     (a),
    .b     (b),
    .lo    (md_lo),
    .hi    (md_hi),
    .done  (md_done)
  );

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    dif   = {1'b0, a} - {1'b0, b};
    sc_lo = sum[WIDTH-1:0];
    sc_hi = '0;
    sc_c  = sum[WIDTH];
    sc_dz = 1'b0;
    case (bus.Select_Input)
      OP_SUB:  begin sc_lo = dif[WIDTH-1:0]; sc_c = dif[WIDTH]; end
      // Only reached with a zero divisor
      OP_DIV:  begin sc_lo = '1; sc_hi = a; sc_c = 1'b0; sc_dz = 1'b1; end
      OP_SHL:  begin sc_lo = {a[WIDTH-2:0], 1'b0}; sc_c = a[WIDTH-1]; end
      OP_SHR:  begin sc_lo = {1'b0, a[WIDTH-1:1]}; sc_c = a[0]; end
      OP_AND:  begin sc_lo = a & b;    sc_c = 1'b0; end
      OP_OR:   begin sc_lo = a | b;    sc_c = 1'b0; end
      OP_XOR:  begin sc_lo = a ^ b;    sc_c = 1'b0; end
      OP_NOR:  begin sc_lo = ~(a | b); sc_c = 1'b0; end
      OP_NAND: begin sc_lo = ~(a & b); sc_c = 1'b0; end
      OP_XNOR: begin sc_lo = ~(a ^ b); sc_c = 1'b0; end
      OP_GT:   begin sc_lo = {{(WIDTH-1){1'b0}}, a > b};  sc_c = 1'b0; end
      OP_EQ:   begin sc_lo = {{(WIDTH-1){1'b0}}, a == b}; sc_c = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state             <= S_IDLE;
      op_div            <= 1'b0;
      bus.In_Ready      <= 1'b1;
      bus.Out_Valid     <= 1'b0;
      bus.Output_Signal <= '0;
      bus.Output_High   <= '0;
      bus.Carry_Output  <= 1'b0;
      bus.Zero_Flag     <= 1'b0;
      bus.Div_By_Zero   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.In_Valid) begin
          bus.In_Ready <= 1'b0;
          op_div       <= (bus.Select_Input == OP_DIV);
          if (iter_op) begin
            state <= S_BUSY;
          end else begin
            bus.Output_Signal <= sc_lo;
            bus.Output_High   <= sc_hi;
            bus.Carry_Output  <= sc_c;
            bus.Zero_Flag     <= (sc_lo == '0);
            bus.Div_By_Zero   <= sc_dz;
            bus.Out_Valid     <= 1'b1;
            state             <= S_DONE;
          end
        end
        S_BUSY: if (md_done) begin
          bus.Output_Signal <= md_lo;
          bus.Output_High   <= md_hi;
          bus.Carry_Output  <= !op_div && (md_hi != '0);
          bus.Zero_Flag     <= (md_lo == '0);
          bus.Div_By_Zero   <= 1'b0;
          bus.Out_Valid     <= 1'b1;
          state             <= S_DONE;
        end
        S_DONE: if (bus.Out_Ready) begin
          bus.Out_Valid <= 1'b0;
          bus.In_Ready  <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Drives WIDTH=8 and WIDTH=16 instances in lockstep and checks both every cycle
// against an arithmetic reference model, plus hand-computed literals.
module tb_alu_seq;
  import alu_seq_pkg::*;

  typedef struct {
    logic [15:0] lo, hi;
    logic        c, z, dz;
    int          lat;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0]  sel = 4'h0;
  logic [15:0] a = 16'h0, b = 16'h0;

  alu_seq_if #(.WIDTH(8))  if8 ();
  alu_seq_if #(.WIDTH(16)) if16 ();

  assign if8.In_Valid      = in_valid;
  assign if8.Out_Ready     = out_ready;
  assign if8.Select_Input  = sel;
  assign if8.Input_1       = a[7:0];
  assign if8.Input_2       = b[7:0];
  assign if16.In_Valid     = in_valid;
  assign if16.Out_Ready    = out_ready;
  assign if16.Select_Input = sel;
  assign if16.Input_1      = a;
  assign if16.Input_2      = b;

  alu_seq #(.WIDTH(8))  dut8  (.Clock(clk), .Reset(rst), .bus(if8.slave));
  alu_seq #(.WIDTH(16)) dut16 (.Clock(clk), .Reset(rst), .bus(if16.slave));

  always #5 clk = ~clk;

  logic [1:0]       ir, ov, cf, zf, dzf;
  logic [1:0][15:0] os, oh;
  assign ir[0] = if8.In_Ready;      assign ir[1] = if16.In_Ready;
  assign ov[0] = if8.Out_Valid;     assign ov[1] = if16.Out_Valid;
  assign cf[0] = if8.Carry_Output;  assign cf[1] = if16.Carry_Output;
  assign zf[0] = if8.Zero_Flag;     assign zf[1] = if16.Zero_Flag;
  assign dzf[0] = if8.Div_By_Zero;  assign dzf[1] = if16.Div_By_Zero;
  assign os[0] = {8'h00, if8.Output_Signal};  assign os[1] = if16.Output_Signal;
  assign oh[0] = {8'h00, if8.Output_High};    assign oh[1] = if16.Output_High;

  int tests = 0, fails = 0;

  task automatic check(input int w, input string nm, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL w%0d %s: got 0x%0h, want 0x%0h", w, nm, act, req);
    end
  endtask

  function automatic exp_t model(input int w, input logic [3:0] op, input logic [15:0] x, y);
    exp_t e;
    longint unsigned m, av, bv, r;
    m = (64'd1 << w) - 1;
    av = x & m;
    bv = y & m;
    e.hi = 16'h0; e.c = 1'b0; e.dz = 1'b0; e.lat = 1;
    case (op)
      OP_SUB:  begin r = (av - bv) & m; e.c = (av < bv); end
      OP_MUL:  begin r = av * bv; e.hi = 16'(r >> w); r = r & m; e.c = (e.hi != 0); e.lat = w + 1; end
      OP_DIV:  if (bv == 0) begin r = m; e.hi = 16'(av); e.dz = 1'b1; end
               else begin r = av / bv; e.hi = 16'(av % bv); e.lat = w + 1; end
      OP_SHL:  begin r = (av << 1) & m; e.c = ((av >> (w - 1)) & 1) != 0; end
      OP_SHR:  begin r = av >> 1; e.c = (av & 1) != 0; end
      OP_AND:  r = av & bv;
      OP_OR:   r = av | bv;
      OP_XOR:  r = av ^ bv;
      OP_NOR:  r = ~(av | bv) & m;
      OP_NAND: r = ~(av & bv) & m;
      OP_XNOR: r = ~(av ^ bv) & m;
      OP_GT:   r = (av > bv) ? 1 : 0;
      OP_EQ:   r = (av == bv) ? 1 : 0;
      default: begin r = av + bv; e.c = ((r >> w) != 0); r = r & m; end
    endcase
    e.lo = 16'(r);
    e.z  = (r == 0);
    return e;
  endfunction

  // Per-instance tracker: index 0 is WIDTH=8, index 1 is WIDTH=16
  bit          chk_en = 1'b0;
  bit          trk[2];
  int          age[2], meas_lat[2];
  exp_t        ex[2];
  logic [15:0] got_lo[2], got_hi[2];
  logic        got_c[2], got_z[2], got_dz[2];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int w;
        w = (k == 0) ? 8 : 16;
        if (trk[k]) begin
          age[k]++;
          if (ov[k] && meas_lat[k] < 0) meas_lat[k] = age[k];
          if (ov[k]) begin
            got_lo[k] = os[k]; got_hi[k] = oh[k];
            got_c[k] = cf[k]; got_z[k] = zf[k]; got_dz[k] = dzf[k];
          end
          check(w, "in_ready while busy", ir[k], 0);
          if (age[k] < ex[k].lat) begin
            check(w, "out_valid early", ov[k], 0);
          end else begin
            check(w, "out_valid", ov[k], 1);
            check(w, "result", os[k], ex[k].lo);
            check(w, "high", oh[k], ex[k].hi);
            check(w, "carry", cf[k], ex[k].c);
            check(w, "zero", zf[k], ex[k].z);
            check(w, "div0", dzf[k], ex[k].dz);
          end
        end else begin
          check(w, "idle in_ready", ir[k], 1);
          check(w, "idle out_valid", ov[k], 0);
        end
        if (rst) trk[k] = 1'b0;
        else if (trk[k] && age[k] >= ex[k].lat && ov[k] && out_ready) trk[k] = 1'b0;
        else if (!trk[k] && ir[k] && in_valid) begin
          trk[k] = 1'b1;
          age[k] = 0;
          meas_lat[k] = -1;
          ex[k] = model(w, sel, a, b);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] x, y);
    int n;
    n = 0;
    while (!(ir[0] && ir[1]) && n < 100) begin cyc(); n++; end
    check(0, "issue wait in_ready", (n < 100) ? 1 : 0, 1);
    sel = op; a = x; b = y; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [15:0] x, y, input int hold);
    int n;
    out_ready = (hold == 0);
    issue(op, x, y);
    n = 0;
    if (hold > 0) begin
      while (!(ov[0] && ov[1]) && n < 100) begin cyc(); n++; end
      check(0, "wait out_valid", (n < 100) ? 1 : 0, 1);
      a = ~a; b = ~b; sel = ~sel;
      repeat (hold) cyc();
      out_ready = 1'b1;
      n = 0;
    end
    while (!(ir[0] && ir[1]) && n < 100) begin cyc(); n++; end
    check(0, "wait return to idle", (n < 100) ? 1 : 0, 1);
  endtask

  task automatic check_reset_state();
    for (int k = 0; k < 2; k++) begin
      check(8 * (k + 1), "rst in_ready", ir[k], 1);
      check(8 * (k + 1), "rst out_valid", ov[k], 0);
      check(8 * (k + 1), "rst result", os[k], 0);
      check(8 * (k + 1), "rst high", oh[k], 0);
      check(8 * (k + 1), "rst flags", {cf[k], zf[k], dzf[k]}, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  localparam int NX = 12;
  logic [3:0]  x_op [NX] = '{OP_SUB, OP_SHR, OP_NAND, OP_GT, OP_EQ, 4'b0111,
                             OP_DIV, OP_DIV, OP_OR, OP_AND, OP_NOR, OP_XNOR};
  logic [15:0] x_a  [NX] = '{16'd3, 16'h0081, 16'h00FF, 16'd9, 16'd7, 16'h00FF,
                             16'd7, 16'hFFFF, 16'h1234, 16'h0F0F, 16'h00A5, 16'h5AA5};
  logic [15:0] x_b  [NX] = '{16'd5, 16'd0, 16'h000F, 16'd3, 16'd7, 16'd1,
                             16'd200, 16'd1, 16'h4321, 16'h00FF, 16'h005A, 16'hFFFF};

  initial begin
    exp_t mdl;
    mdl = model(8, OP_ADD, 16'd200, 16'd100);
    check(8, "model add", {mdl.lo, 7'h0, mdl.c, 7'h0, mdl.z}, {16'd44, 8'd1, 8'd0});
    mdl = model(8, OP_MUL, 16'd200, 16'd100);
    check(8, "model mul", {mdl.hi, mdl.lo, 8'(mdl.lat)}, {16'h004E, 16'h0020, 8'd9});
    mdl = model(16, OP_SHL, 16'h8001, 16'd0);
    check(16, "model shl", {mdl.lo, 7'h0, mdl.c}, {16'h0002, 8'd1});

    repeat (3) cyc();
    rst = 1'b0;
    check_reset_state();
    chk_en = 1'b1;

    run_op(OP_ADD, 16'd200, 16'd100, 0);
    check(8, "add lo", got_lo[0], 44);
    check(8, "add c/z", {got_c[0], got_z[0]}, 2'b10);
    check(8, "add latency", meas_lat[0], 1);

    run_op(OP_MUL, 16'd200, 16'd100, 0);
    check(8, "mul lo/hi", {got_hi[0], got_lo[0]}, 32'h004E_0020);
    check(8, "mul carry", got_c[0], 1);
    check(8, "mul latency", meas_lat[0], 9);
    check(16, "mul lo/hi", {got_hi[1], got_lo[1]}, 32'h0000_4E20);

    run_op(OP_DIV, 16'd200, 16'd7, 0);
    check(8, "div q/r", {got_hi[0], got_lo[0]}, {16'd4, 16'd28});
    check(8, "div latency", meas_lat[0], 9);

    run_op(OP_DIV, 16'd5, 16'd0, 0);
    check(8, "div0 q/r", {got_hi[0], got_lo[0]}, {16'd5, 16'h00FF});
    check(8, "div0 flag", got_dz[0], 1);
    check(8, "div0 latency", meas_lat[0], 1);

    run_op(OP_SUB, 16'd5, 16'd5, 5);
    check(8, "sub lo", got_lo[0], 0);
    check(8, "sub z/c", {got_z[0], got_c[0]}, 2'b10);

    out_ready = 1'b1;
    issue(OP_MUL, 16'd200, 16'd100);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset_state();

    run_op(OP_XOR, 16'h00F0, 16'h003C, 0);
    check(8, "xor", got_lo[0], 16'h00CC);

    run_op(OP_SHL, 16'h8001, 16'd0, 0);
    check(16, "shl lo/c", {got_lo[1], 7'h0, got_c[1]}, {16'h0002, 8'd1});

    run_op(OP_MUL, 16'hFFFF, 16'hFFFF, 0);
    check(16, "mul max", {got_hi[1], got_lo[1]}, 32'hFFFE_0001);
    check(16, "mul latency", meas_lat[1], 17);
    check(8, "mul max", {got_hi[0], got_lo[0]}, 32'h00FE_0001);

    for (int i = 0; i < NX; i++) run_op(x_op[i], x_a[i], x_b[i], 0);

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, sequential successor to the team's 8-bit combinational ALU. It uses the same 4-bit opcode map, with a WIDTH-generic datapath, a valid/ready handshake on both sides and registered outputs. Multiply and divide run iteratively over WIDTH cycles and return full-precision results (product high half, remainder). Status flags are added: carry, zero and divide-by-zero. It sits between the operand-issue logic and the result-writeback stage.

Parameters:
WIDTH, 8, operand/result width in bits; must be at least 2.

Ports:
- Clock  input  1  single system clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- In_Valid  input  1  operands and opcode are presented.
- In_Ready  output  1  block can accept an operation.
- Input_1  input  WIDTH  operand A.
- Input_2  input  WIDTH  operand B.
- Select_Input  input  4  opcode, captured on input handshake.
- Out_Valid  output  1  result and flags valid.
- Out_Ready  input  1  consumer accepts the result.
- Output_Signal  output  WIDTH  primary result.
- Output_High  output  WIDTH  product high half for MUL, remainder for DIV, 0 otherwise.
- Carry_Output  output  1  carry/borrow/shifted-out bit.
- Zero_Flag  output  1  Output_Signal == 0.
- Div_By_Zero  output  1  DIV issued with Input_2 == 0.

Behaviour:
- Reset (synchronous, active-high): state IDLE; In_Ready=1; Out_Valid=0; Output_Signal, Output_High, Carry_Output, Zero_Flag and Div_By_Zero all 0. Reset in any state, including mid-iteration, abandons the operation with no output.
- FSM states are IDLE, BUSY and DONE.
- IDLE: In_Ready=1. When In_Valid is high, latch operands and opcode.
  - Opcode 0010 (MUL) or 0011 (DIV) with Input_2 != 0: go to BUSY and load the iteration counter with WIDTH.
  - Any other opcode, or DIV with Input_2 == 0: compute the result, register it and go to DONE.
- BUSY: In_Ready=0. Perform one iteration per cycle (MUL: shift-add; DIV: restoring). When the counter reaches 0, write the results and go to DONE.
- DONE: Out_Valid=1 and In_Ready=0. All outputs are held stable until Out_Ready=1, then go to IDLE and drop Out_Valid in the same edge.
- Latency, measured from the accept edge to the first cycle with Out_Valid=1:
  - single-cycle ops: 1 cycle.
  - MUL/DIV: WIDTH+1 cycles.
  - A new operation can be accepted no earlier than the cycle after the output handshake.
- Opcode map (arithmetic modulo 2^WIDTH unless noted):
  - 0000 ADD: Carry_Output = bit WIDTH of the (WIDTH+1)-bit sum.
  - 0001 SUB: Carry_Output = borrow, i.e. 1 when Input_1 < Input_2.
  - 0010 MUL: the 2*WIDTH-bit product is split into Output_High (upper half) and Output_Signal (lower half). Carry_Output = 1 when Output_High != 0.
  - 0011 DIV: Output_Signal = quotient, Output_High = remainder, Carry_Output = 0.
  - 0100 SHL by 1: Carry_Output = Input_1[WIDTH-1].
  - 0101 SHR by 1 (logical): Carry_Output = Input_1[0].
  - 1000 to 1101: AND, OR, XOR, NOR, NAND, XNOR; Carry_Output = 0.
  - 1110 GT, unsigned: result 1 or 0.
  - 1111 EQ: result 1 or 0.
  - 0110, 0111 (undefined): execute as ADD.
- Divide by zero: Output_Signal = all ones, Output_High = Input_1, Div_By_Zero=1, 1-cycle latency. Div_By_Zero is 0 for every other result.
- Zero_Flag is computed from the final Output_Signal only.
- In_Valid while In_Ready=0 is ignored; the source must hold its request until handshake.
- Operands are captured at accept, so input changes during BUSY or DONE do not affect the result.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams (OP_ADD through OP_EQ);
  - FSM state encoding (IDLE, BUSY, DONE);
  - counter-width function clog2(WIDTH+1).
- One sub-module, alu_iter_muldiv: WIDTH-parametrised iterative shift-add multiplier and restoring divider.
  - Inputs: start, mode, operands.
  - Outputs: lo, hi, done.
  - The top holds the FSM, handshake, single-cycle ops and flags.

Test Plan:
- WIDTH=8, ADD 200+100, Out_Ready=1 -> Out_Valid 1 cycle after accept; Output_Signal=44, Carry_Output=1, Zero_Flag=0.
- MUL 200*100 -> Out_Valid exactly 9 cycles after accept; Output_Signal=0x20, Output_High=0x4E, Carry_Output=1; In_Ready=0 throughout.
- DIV 200/7 -> Output_Signal=28, Output_High=4 after 9 cycles; DIV 5/0 -> 1 cycle, Output_Signal=0xFF, Output_High=5, Div_By_Zero=1.
- SUB 5-5 with Out_Ready held low for 5 cycles, and operand inputs changed meanwhile -> Output_Signal=0, Zero_Flag=1, Carry_Output=0, all outputs stable; IDLE follows the Out_Ready handshake.
- Reset asserted 3 cycles into a MUL -> next cycle shows IDLE, In_Ready=1, Out_Valid=0 and all outputs 0. A subsequent XOR 0xF0^0x3C yields 0xCC.
- WIDTH=16 rerun: SHL 0x8001 -> 0x0002 with Carry_Output=1; MUL 0xFFFF*0xFFFF -> lo 0x0001, hi 0xFFFE, latency 17 cycles.
